// File: rtl/dmem_lsu_pkg.sv
// Shared constants and helpers for the dmem_lsu load/store unit.
// Optional bus timeout in the top is enabled by defining DMEM_LSU_TIMEOUT_EN.
package dmem_lsu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] a);
    case (size_e'(funct3[1:0]))
      SZ_BYTE: be_gen = 4'b0001 << a;
      SZ_HALF: be_gen = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be_gen = 4'b1111;
      default: be_gen = 4'b0000;
    endcase
  endfunction

  // Stores only have the three signed encodings; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic [2:0] funct3, input logic we);
    if (we)
      f3_legal = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    else
      f3_legal = (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
                 (funct3 == F3_LBU) || (funct3 == F3_LHU);
  endfunction

  function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] a);
    case (size_e'(funct3[1:0]))
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~a[0];
      SZ_WORD: is_aligned = (a == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering for dmem_lsu: store lane replication and
// load lane select with sign/zero extension.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_wdata,
  output logic [31:0] o_st_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_raw,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (size_e'(i_st_size))
      SZ_BYTE: o_st_wdata = {4{i_st_wdata[7:0]}};
      SZ_HALF: o_st_wdata = {2{i_st_wdata[15:0]}};
      default: o_st_wdata = i_st_wdata;
    endcase
  end

  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_raw[7:0];
      2'd1:    w_byte = i_ld_raw[15:8];
      2'd2:    w_byte = i_ld_raw[23:16];
      default: w_byte = i_ld_raw[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
    case (i_ld_funct3)
      F3_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_ld_data = {24'd0, w_byte};
      F3_LHU:  o_ld_data = {16'd0, w_half};
      default: o_ld_data = i_ld_raw;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit bridging the core datapath to a handshaked data-memory bus.
// Define DMEM_LSU_TIMEOUT_EN to abort transfers that wait TIMEOUT cycles for bus ack.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_stall,
  output logic [31:0]       o_rdata,
  output logic              o_misalign,
  output logic              o_bus_err,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [3:0]        o_bus_be,
  output logic [31:0]       o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata
);

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;

  logic        w_idle_req;
  logic        w_fault;
  logic        w_start;
  logic        w_expire;
  logic [31:0] w_st_wdata;
  logic [31:0] w_ld_data;

  assign w_idle_req = i_req_valid & (r_state == ST_IDLE);
  assign w_fault    = w_idle_req &
                      ~(f3_legal(i_req_funct3, i_req_we) & is_aligned(i_req_funct3, i_req_addr[1:0]));
  assign w_start    = w_idle_req & ~w_fault;

  lsu_align u_align (
    .i_st_size    (i_req_funct3[1:0]),
    .i_st_wdata   (i_req_wdata),
    .o_st_wdata   (w_st_wdata),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr[1:0]),
    .i_ld_raw     (r_rdata),
    .o_ld_data    (w_ld_data)
  );

`ifdef DMEM_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_tcnt;
  logic             r_err;

  assign w_expire = (r_state == ST_BUS) & ~i_bus_ack & (r_tcnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start)
        r_tcnt <= '0;
      else if ((r_state == ST_BUS) && !i_bus_ack)
        r_tcnt <= r_tcnt + 1'b1;
      if (r_state == ST_BUS)
        r_err <= w_expire;
    end
  end

  assign o_bus_err = (r_state == ST_DONE) & r_err;
`else
  assign w_expire  = 1'b0;
  assign o_bus_err = 1'b0;
`endif

  // A timed-out transfer captures zero so the DONE cycle returns rdata=0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_BUS;
            r_addr   <= i_req_addr;
            r_we     <= i_req_we;
            r_funct3 <= i_req_funct3;
            r_be     <= be_gen(i_req_funct3, i_req_addr[1:0]);
            r_wdata  <= w_st_wdata;
          end
        end
        ST_BUS: begin
          if (i_bus_ack) begin
            r_rdata <= i_bus_rdata;
            r_state <= ST_DONE;
          end else if (w_expire) begin
            r_rdata <= 32'd0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_stall     = ~i_rst & i_req_valid & (r_state != ST_DONE) & ~w_fault;
  assign o_misalign  = ~i_rst & w_fault;
  assign o_rdata     = ((r_state == ST_DONE) && !r_we) ? w_ld_data : 32'd0;
  assign o_bus_req   = (r_state == ST_BUS);
  assign o_bus_we    = r_we;
  assign o_bus_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign o_bus_be    = r_be;
  assign o_bus_wdata = r_wdata;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard testbench for dmem_lsu; define DMEM_LSU_TIMEOUT_EN to also cover the bus timeout.
module tb_dmem_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqWe;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misalign;
  logic        busErr;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic        busAck;
  logic [31:0] busRdata;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (reqValid),
    .i_req_we     (reqWe),
    .i_req_funct3 (reqFunct3),
    .i_req_addr   (reqAddr),
    .i_req_wdata  (reqWdata),
    .o_stall      (stall),
    .o_rdata      (rdata),
    .o_misalign   (misalign),
    .o_bus_err    (busErr),
    .o_bus_req    (busReq),
    .o_bus_we     (busWe),
    .o_bus_addr   (busAddr),
    .o_bus_be     (busBe),
    .o_bus_wdata  (busWdata),
    .i_bus_ack    (busAck),
    .i_bus_rdata  (busRdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] baddr;
    logic        we;
    logic        fault;
    logic        err;
    int          stallCycles;
    int          busCycles;
  } exp_t;

  exp_t scoreQ[$];
  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Reference behaviour built from byte-level reasoning about the request.
  function automatic exp_t modelExpect(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] wd, input int waits, input logic [31:0] rd);
    exp_t e;
    logic legal;
    logic aligned;
    logic [31:0] lane;
    logic [31:0] halfLane;
    e = '{rdata: 32'd0, be: 4'd0, bwdata: 32'd0, baddr: 32'd0, we: we, fault: 1'b0, err: 1'b0,
          stallCycles: 0, busCycles: 0};
    legal   = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    aligned = (f3[1:0] == 2'd0) || (f3[1:0] == 2'd1 && !addr[0]) || (f3[1:0] == 2'd2 && addr[1:0] == 2'd0);
    if (!(legal && aligned)) begin
      e.fault = 1'b1;
      return e;
    end
    e.baddr = addr & 32'hFFFF_FFFC;
    lane     = rd >> (8 * addr[1:0]);
    halfLane = rd >> (16 * addr[1]);
    case (f3[1:0])
      2'd0: begin
        e.be     = (addr[1:0] == 0) ? 4'h1 : (addr[1:0] == 1) ? 4'h2 : (addr[1:0] == 2) ? 4'h4 : 4'h8;
        e.bwdata = wd[7:0] * 32'h0101_0101;
      end
      2'd1: begin
        e.be     = addr[1] ? 4'hC : 4'h3;
        e.bwdata = wd[15:0] * 32'h0001_0001;
      end
      default: begin
        e.be     = 4'hF;
        e.bwdata = wd;
      end
    endcase
    if (!we) begin
      case (f3)
        3'd0:    e.rdata = lane[7] ? (32'hFFFF_FF00 | lane[7:0]) : {24'd0, lane[7:0]};
        3'd4:    e.rdata = {24'd0, lane[7:0]};
        3'd1:    e.rdata = halfLane[15] ? (32'hFFFF_0000 | halfLane[15:0]) : {16'd0, halfLane[15:0]};
        3'd5:    e.rdata = {16'd0, halfLane[15:0]};
        default: e.rdata = rd;
      endcase
    end
    if (waits < 0) begin
      e.rdata       = 32'd0;
      e.err         = 1'b1;
      e.stallCycles = TIMEOUT + 1;
      e.busCycles   = TIMEOUT;
    end else begin
      e.stallCycles = 2 + waits;
      e.busCycles   = waits + 1;
    end
    return e;
  endfunction

  // Drives one instruction; waits<0 means the bus never acknowledges.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input int waits, input logic [31:0] rd);
    exp_t e;
    exp_t h;
    int busCycles = 0;
    int stallCnt  = 0;
    bit sawReq    = 0;
    bit done      = 0;
    scoreQ.push_back(modelExpect(we, f3, addr, wd, waits, rd));
    reqValid  = 1'b1;
    reqWe     = we;
    reqFunct3 = f3;
    reqAddr   = addr;
    reqWdata  = wd;
    for (int c = 0; c < TIMEOUT + 40 && !done; c++) begin
      @(negedge clk);
      if (busReq) begin
        if (!sawReq) begin
          h = scoreQ[0];
          checkOutput("bus_be", {28'd0, busBe}, {28'd0, h.be});
          checkOutput("bus_addr", busAddr, h.baddr);
          checkOutput("bus_we", {31'd0, busWe}, {31'd0, h.we});
          if (h.we) checkOutput("bus_wdata", busWdata, h.bwdata);
        end
        sawReq = 1;
        busCycles++;
        if (waits >= 0 && busCycles == waits + 1) begin
          busAck   = 1'b1;
          busRdata = rd;
        end
      end
      if (stall) begin
        stallCnt++;
      end else begin
        e = scoreQ.pop_front();
        checkOutput("rdata", rdata, e.rdata);
        checkOutput("misalign", {31'd0, misalign}, {31'd0, e.fault});
        checkOutput("bus_err", {31'd0, busErr}, {31'd0, e.err});
        checkOutput("bus_req_retire", {31'd0, busReq}, 32'd0);
        checkOutput("stall_cycles", stallCnt, e.stallCycles);
        checkOutput("bus_cycles", busCycles, e.busCycles);
        done = 1;
      end
      @(posedge clk);
      #1;
      busAck   = 1'b0;
      busRdata = $urandom;
    end
    if (!done) begin
      checkOutput("retire_bound", 32'd0, 32'd1);
      if (scoreQ.size() > 0) void'(scoreQ.pop_front());
    end
    reqValid = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    @(negedge clk);
    checkOutput({tag, "_stall"}, {31'd0, stall}, 32'd0);
    checkOutput({tag, "_bus_req"}, {31'd0, busReq}, 32'd0);
    checkOutput({tag, "_bus_we"}, {31'd0, busWe}, 32'd0);
    checkOutput({tag, "_bus_addr"}, busAddr, 32'd0);
    checkOutput({tag, "_bus_be"}, {28'd0, busBe}, 32'd0);
    checkOutput({tag, "_bus_wdata"}, busWdata, 32'd0);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_misalign"}, {31'd0, misalign}, 32'd0);
    checkOutput({tag, "_bus_err"}, {31'd0, busErr}, 32'd0);
  endtask

  initial begin
    logic [2:0] legalF3 [5];
    logic [2:0] f3;
    logic       we;
    logic [31:0] addr;
    legalF3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst = 1'b1; reqValid = 1'b0; reqWe = 1'b0; reqFunct3 = 3'd0;
    reqAddr = 32'd0; reqWdata = 32'd0; busAck = 1'b0; busRdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkIdleOutputs("reset");
    @(posedge clk); #1;

    applyStimulus(1'b0, 3'd2, 32'h0000_1000, 32'd0, 2, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 3'd0, 32'h0000_1003, 32'd0, 0, 32'h8012_3456);
    applyStimulus(1'b0, 3'd4, 32'h0000_1003, 32'd0, 1, 32'h8012_3456);
    applyStimulus(1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 0, 32'd0);
    applyStimulus(1'b0, 3'd2, 32'h0000_1002, 32'd0, 0, 32'h5555_5555);
    applyStimulus(1'b0, 3'd1, 32'h0000_1001, 32'd0, 0, 32'd0);
    applyStimulus(1'b0, 3'd3, 32'h0000_1000, 32'd0, 0, 32'd0);
    applyStimulus(1'b1, 3'd6, 32'h0000_1000, 32'h0BAD_0BAD, 0, 32'd0);
    applyStimulus(1'b1, 3'd2, 32'h0000_1001, 32'h0BAD_0BAD, 0, 32'd0);
    applyStimulus(1'b0, 3'd5, 32'h0000_1002, 32'd0, 3, 32'hBEEF_1234);
    applyStimulus(1'b0, 3'd1, 32'h0000_1000, 32'd0, 0, 32'h0000_8001);
    applyStimulus(1'b1, 3'd0, 32'h0000_3001, 32'h0000_00AA, 2, 32'd0);
    applyStimulus(1'b1, 3'd2, 32'h0000_4000, 32'hCAFE_F00D, 1, 32'd0);

    for (int i = 0; i < 10; i++) begin
      we   = 1'($urandom_range(0, 1));
      f3   = we ? 3'($urandom_range(0, 2)) : legalF3[$urandom_range(0, 4)];
      addr = $urandom;
      if (f3[1:0] == 2'd1) addr[0] = 1'b0;
      if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      applyStimulus(we, f3, addr, $urandom, int'($urandom_range(0, 3)), $urandom);
    end

    busAck = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checkOutput("stray_ack_bus_req", {31'd0, busReq}, 32'd0);
      checkOutput("stray_ack_stall", {31'd0, stall}, 32'd0);
    end
    @(posedge clk); #1 busAck = 1'b0;
    applyStimulus(1'b0, 3'd2, 32'h0000_6000, 32'd0, 1, 32'h0123_4567);

    reqValid = 1'b1; reqWe = 1'b1; reqFunct3 = 3'd2; reqAddr = 32'h0000_5004; reqWdata = 32'h1122_3344;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("mid_bus_req", {31'd0, busReq}, 32'd1);
    rst = 1'b1; reqValid = 1'b0;
    @(posedge clk); #1;
    checkIdleOutputs("mid_reset");
    @(posedge clk); #1 rst = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0000_7001, 32'd0, 0, 32'h0000_FE00);

`ifdef DMEM_LSU_TIMEOUT_EN
    applyStimulus(1'b0, 3'd2, 32'h0000_8000, 32'd0, -1, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 3'd2, 32'h0000_8004, 32'd0, 0, 32'h7777_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
